uart_msg_tx: RTL

Transmit-side companion to the Bluetooth UART receive path. It accepts a status-event code from the CPU controller over a 4-phase req/ack handshake and builds the matching ASCII status message ("FIM-3-#" and so on). It then serialises the message as 8N1 frames at 115200 baud on the Bluetooth module's RX pin, clocked from the 50 MHz board clock.

---
 rtl/uart_pkg.sv | 59 +++++
 rtl/uart_msg_tx_if.sv | 11 +
 rtl/uart_tx_byte.sv | 117 +++++++++++
 rtl/uart_msg_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and message helpers for the Bluetooth UART
// transmit path.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_MAX_LEN      = 9;

  localparam logic [3:0] EV_FIM = 4'd1;
  localparam logic [3:0] EV_BPM = 4'd2;
  localparam logic [3:0] EV_BDM = 4'd3;
  localparam logic [3:0] EV_FRM = 4'd4;
  localparam logic [3:0] EV_END = 4'd5;

  localparam logic [7:0] ASC_DASH = 8'h2D;
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_X    = 8'h58;
  localparam logic [7:0] ASC_ZERO = 8'h30;

  // Message lengths including the terminating '#'
  localparam int LEN_UNIT = 7;
  localparam int LEN_END  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_ACK_WAIT
  } msg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic code_valid(input logic [3:0] code);
    return (code >= EV_FIM) && (code <= EV_END);
  endfunction

  function automatic logic [23:0] msg_prefix(input logic [3:0] code);
    logic [23:0] pfx;
    case (code)
      EV_FIM:  pfx = "FIM";
      EV_BPM:  pfx = "BPM";
      EV_BDM:  pfx = "BDM";
      EV_FRM:  pfx = "FRM";
      EV_END:  pfx = "END";
      default: pfx = {ASC_X, ASC_X, ASC_X};
    endcase
    return pfx;
  endfunction

  function automatic logic [7:0] arg_char(input logic [3:0] arg);
    return (arg <= 4'd9) ? (ASC_ZERO + {4'b0000, arg}) : ASC_X;
  endfunction

endpackage

// File: rtl/uart_msg_tx_if.sv
// Four-phase request/acknowledge bus between the CPU controller and the
// status-message transmitter.
interface uart_msg_tx_if;
  logic       req;
  logic [3:0] msg_code;
  logic [3:0] msg_arg;
  logic       ack;

  modport master (output req, output msg_code, output msg_arg, input ack);
  modport slave  (input req, input msg_code, input msg_arg, output ack);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. o_done marks the final cycle of the stop bit; a start
// request in that cycle chains the next byte with no idle gap.
//
// state    | meaning
// TX_IDLE  | line idle high, waiting for i_start
// TX_START | start bit (low), CLKS_PER_BIT cycles
// TX_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// TX_STOP  | stop bit (high), CLKS_PER_BIT cycles
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_cnt_tc;

  assign w_cnt_tc = (r_cnt == CNT_LAST);
  assign o_done   = (r_state == TX_STOP) && w_cnt_tc;
  assign o_ready  = (r_state == TX_IDLE) || o_done;
  assign o_tx     = r_tx;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_start) begin
          w_state_nxt = TX_START;
          w_cnt_nxt   = '0;
          w_shift_nxt = i_data;
          w_tx_nxt    = 1'b0;
        end
      end
      TX_START: begin
        if (w_cnt_tc) begin
          w_state_nxt = TX_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (w_cnt_tc) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = TX_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (w_cnt_tc) begin
          w_cnt_nxt = '0;
          if (i_start) begin
            w_state_nxt = TX_START;
            w_shift_nxt = i_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = TX_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Status-message transmitter: accepts an event code over req/ack, builds the
// ASCII message and sends it as back-to-back 8N1 characters.
//
// state       | meaning
// ST_IDLE     | waiting for req with ack and busy low
// ST_LOAD     | code latched; raise ack, build buffer or reject invalid code
// ST_SEND     | serialiser busy; chains next character at each stop-bit end
// ST_NEXT     | final stop bit finished; tx_done high this cycle
// ST_ACK_WAIT | wait for req to fall (or ack already dropped)
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MAX_LEN      = DEF_MAX_LEN
) (
  input  logic         clk_50M,
  input  logic         rst_n,
  uart_msg_tx_if.slave bus,
  output logic         tx,
  output logic         busy,
  output logic         tx_done
);

  localparam int IW = $clog2(MAX_LEN);

  msg_state_t    r_state, w_state_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic [3:0]    r_arg, w_arg_nxt;
  logic [7:0]    r_buf [MAX_LEN];
  logic [7:0]    w_buf_nxt [MAX_LEN];
  logic [7:0]    w_msg [MAX_LEN];
  logic [IW-1:0] r_idx, w_idx_nxt, w_idx_inc;
  logic [IW-1:0] r_last, w_last_nxt, w_msg_last;
  logic          r_ack, w_ack_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_tx_done, w_tx_done_nxt;
  logic [23:0]   w_pfx;
  logic          w_start, w_ready, w_byte_done;
  logic [7:0]    w_byte;

  assign w_idx_inc = r_idx + IW'(1);
  assign bus.ack   = r_ack;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_data  (w_byte),
    .o_tx    (tx),
    .o_ready (w_ready),
    .o_done  (w_byte_done)
  );

  // Message image built from the latched code/arg, not the live bus inputs
  always_comb begin
    w_pfx = msg_prefix(r_code);
    for (int i = 0; i < MAX_LEN; i++) w_msg[i] = ASC_HASH;
    w_msg[0] = w_pfx[23:16];
    w_msg[1] = w_pfx[15:8];
    w_msg[2] = w_pfx[7:0];
    w_msg[3] = ASC_DASH;
    if (r_code == EV_END) begin
      w_msg_last = IW'(LEN_END - 1);
    end else begin
      w_msg[4]   = arg_char(r_arg);
      w_msg[5]   = ASC_DASH;
      w_msg_last = IW'(LEN_UNIT - 1);
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_arg     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
    end else begin
      r_code    <= w_code_nxt;
      r_arg     <= w_arg_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_tx_done <= w_tx_done_nxt;
      r_buf     <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_arg_nxt     = r_arg;
    w_buf_nxt     = r_buf;
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_ack_nxt     = r_ack && bus.req;
    w_busy_nxt    = r_busy;
    w_tx_done_nxt = 1'b0;
    w_start       = 1'b0;
    w_byte        = r_buf[w_idx_inc];
    case (r_state)
      ST_IDLE: begin
        if (bus.req && !r_ack && !r_busy) begin
          w_code_nxt  = bus.msg_code;
          w_arg_nxt   = bus.msg_arg;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ack_nxt = 1'b1;
        if (!code_valid(r_code)) begin
          w_state_nxt = ST_ACK_WAIT;
        end else if (w_ready) begin
          w_buf_nxt   = w_msg;
          w_last_nxt  = w_msg_last;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_start     = 1'b1;
          w_byte      = w_msg[0];
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // Decide at the stop bit's last cycle so the next start bit abuts it
        if (w_byte_done) begin
          if (r_idx < r_last) begin
            w_idx_nxt = w_idx_inc;
            w_start   = 1'b1;
          end else begin
            w_busy_nxt    = 1'b0;
            w_tx_done_nxt = 1'b1;
            w_state_nxt   = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        w_state_nxt = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (!bus.req || !r_ack) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
